wb_arb_stage: RTL and testbench

Parametrised writeback stage for the RV32 core. Merges the in-order pipeline result with results from long-latency units (mul/div, future FPU) onto the single register-file write port. Long-latency results are buffered in a small FIFO, and an age counter guarantees they are not starved. It also performs load data extraction (byte/half/word, sign/zero extension) before the writeback mux.

---
 rtl/wb_arb_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_wb_arb_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_stage
// Purpose  : RV32 writeback stage. Merges the in-order pipeline result with
//            long-latency unit results onto the single register-file write
//            port. Long-latency results are queued in a small FIFO. An age
//            counter on the FIFO head stalls the pipeline so the queue is
//            never starved. Load data extraction (byte/half/word with
//            sign/zero extension) is performed ahead of the writeback mux.
// Config   : `WB_LOAD_SUBWORD_EN - when defined, byte/half lane selection and
//            extension are built. When undefined, load data is the raw memory
//            word, and addr_lo/mem_size/mem_unsigned are ignored.
// Ports    : clk, rst (async, active-high)
//            i_pipe_*      pipeline slot (valid, results, load info, rd, sel)
//            o_wb_stall    pipeline slot not consumed; upstream holds inputs
//            i_ll_valid/o_ll_ready/i_ll_rd/i_ll_data  long-latency push side
//            o_rf_we/o_rf_waddr/o_rf_wdata            registered RF write port
//            o_ll_pending  FIFO non-empty
// Revision : 1.0 - initial release
// ============================================================================
module wb_arb_stage #(
  parameter int XLEN       = 32,
  parameter int LL_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  // pipeline slot
  input  logic            i_pipe_valid,
  input  logic [XLEN-1:0] i_pipe_opr_res,
  input  logic [XLEN-1:0] i_pipe_dmem_rdata,
  input  logic [1:0]      i_pipe_addr_lo,
  input  logic [1:0]      i_pipe_mem_size,
  input  logic            i_pipe_mem_unsigned,
  input  logic [4:0]      i_pipe_rd,
  input  logic [XLEN-1:0] i_pipe_pc4,
  input  logic            i_pipe_rf_en,
  input  logic [1:0]      i_pipe_wb_sel,
  output logic            o_wb_stall,
  // long-latency results
  input  logic            i_ll_valid,
  output logic            o_ll_ready,
  input  logic [4:0]      i_ll_rd,
  input  logic [XLEN-1:0] i_ll_data,
  // register-file write port
  output logic            o_rf_we,
  output logic [4:0]      o_rf_waddr,
  output logic [XLEN-1:0] o_rf_wdata,
  output logic            o_ll_pending
);

  localparam int c_ptr_w = (LL_DEPTH > 1) ? $clog2(LL_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(LL_DEPTH) + 1;
  localparam int c_age_w = $clog2(STARVE_MAX + 1);

  localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(LL_DEPTH);
  localparam logic [c_age_w-1:0] c_starve = c_age_w'(STARVE_MAX);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [4:0]         r_mem_rd   [LL_DEPTH];
  logic [XLEN-1:0]    r_mem_data [LL_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_age_w-1:0] r_age;

  logic               r_rf_we;
  logic [4:0]         r_rf_waddr;
  logic [XLEN-1:0]    r_rf_wdata;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic            w_pipe_req;
  logic            w_empty;
  logic            w_full;
  logic            w_starve;
  logic            w_pop;
  logic            w_push;
  logic            w_pipe_take;
  logic [4:0]      w_head_rd;
  logic [XLEN-1:0] w_head_data;

  assign w_pipe_req  = i_pipe_valid & i_pipe_rf_en;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_depth);
  // Head has waited its full budget: it wins the port even over the pipe.
  assign w_starve    = ~w_empty & (r_age == c_starve);
  assign w_pop       = ~w_empty & (w_starve | ~w_pipe_req);
  assign w_pipe_take = w_pipe_req & ~w_starve;

  assign o_ll_ready   = ~w_full & ~rst;
  assign w_push       = i_ll_valid & o_ll_ready;
  assign o_wb_stall   = w_pipe_req & w_starve;
  assign o_ll_pending = ~w_empty;

  assign w_head_rd   = r_mem_rd[r_rd_ptr];
  assign w_head_data = r_mem_data[r_rd_ptr];

  // --------------------------------------------------------------------------
  // Load data extraction
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_load_data;

`ifdef WB_LOAD_SUBWORD_EN
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  always_comb begin
    w_ld_byte = i_pipe_dmem_rdata[7:0];
    case (i_pipe_addr_lo)
      2'd0:    w_ld_byte = i_pipe_dmem_rdata[7:0];
      2'd1:    w_ld_byte = i_pipe_dmem_rdata[15:8];
      2'd2:    w_ld_byte = i_pipe_dmem_rdata[23:16];
      default: w_ld_byte = i_pipe_dmem_rdata[31:24];
    endcase
    // Halfwords are naturally aligned, so only addr_lo[1] selects the lane.
    w_ld_half = i_pipe_addr_lo[1] ? i_pipe_dmem_rdata[31:16]
                                  : i_pipe_dmem_rdata[15:0];

    case (i_pipe_mem_size)
      2'b00: begin
        if (i_pipe_mem_unsigned)
          w_load_data = {{(XLEN-8){1'b0}}, w_ld_byte};
        else
          w_load_data = {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte};
      end
      2'b01: begin
        if (i_pipe_mem_unsigned)
          w_load_data = {{(XLEN-16){1'b0}}, w_ld_half};
        else
          w_load_data = {{(XLEN-16){w_ld_half[15]}}, w_ld_half};
      end
      default: w_load_data = i_pipe_dmem_rdata;
    endcase
  end
`else
  // Sub-word controls have no function in this build.
  logic w_unused_ld_ctrl;
  assign w_unused_ld_ctrl = ^{i_pipe_addr_lo, i_pipe_mem_size, i_pipe_mem_unsigned};
  assign w_load_data      = i_pipe_dmem_rdata;
`endif

  // --------------------------------------------------------------------------
  // Pipeline writeback select
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_pipe_wdata;

  always_comb begin
    w_pipe_wdata = '0;
    case (i_pipe_wb_sel)
      2'b00:   w_pipe_wdata = i_pipe_opr_res;
      2'b01:   w_pipe_wdata = w_load_data;
      2'b10:   w_pipe_wdata = i_pipe_pc4;
      default: w_pipe_wdata = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO storage (contents need no reset; pointers/count guard validity)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr]   <= i_ll_rd;
      r_mem_data[r_wr_ptr] <= i_ll_data;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO control and age counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_age    <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase

      // Age tracks how long the current head has waited; a push into an
      // empty FIFO starts the new head at zero.
      if (w_pop || w_empty)
        r_age <= '0;
      else if (r_age != c_starve)
        r_age <= r_age + c_age_w'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Registered register-file write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else if (w_pop) begin
      // x0 entries still drain from the FIFO but never write.
      r_rf_we    <= (w_head_rd != 5'd0);
      r_rf_waddr <= w_head_rd;
      r_rf_wdata <= w_head_data;
    end else if (w_pipe_take) begin
      r_rf_we    <= (i_pipe_rd != 5'd0);
      r_rf_waddr <= i_pipe_rd;
      r_rf_wdata <= w_pipe_wdata;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  assign o_rf_we    = r_rf_we;
  assign o_rf_waddr = r_rf_waddr;
  assign o_rf_wdata = r_rf_wdata;

endmodule
`default_nettype wire

// File: tb/tb_wb_arb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arb_stage
// Purpose  : Directed self-checking bench for wb_arb_stage (default
//            parameters XLEN=32, LL_DEPTH=2, STARVE_MAX=4). Load-extraction
//            expectations follow `WB_LOAD_SUBWORD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [31:0] pipe_opr_res;
  logic [31:0] pipe_dmem_rdata;
  logic [1:0]  pipe_addr_lo;
  logic [1:0]  pipe_mem_size;
  logic        pipe_mem_unsigned;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_pc4;
  logic        pipe_rf_en;
  logic [1:0]  pipe_wb_sel;
  logic        wb_stall;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ll_pending;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] c_raw = 32'h80FF_7F01;
  localparam logic [31:0] c_b1  = 32'h1111_0000;
  localparam logic [31:0] c_b2  = 32'h2222_0000;
  localparam logic [31:0] c_d   = 32'hD000_0000;

  always #5 clk = ~clk;

  wb_arb_stage #(.XLEN(32), .LL_DEPTH(2), .STARVE_MAX(4)) u_dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_pipe_valid        (pipe_valid),
    .i_pipe_opr_res      (pipe_opr_res),
    .i_pipe_dmem_rdata   (pipe_dmem_rdata),
    .i_pipe_addr_lo      (pipe_addr_lo),
    .i_pipe_mem_size     (pipe_mem_size),
    .i_pipe_mem_unsigned (pipe_mem_unsigned),
    .i_pipe_rd           (pipe_rd),
    .i_pipe_pc4          (pipe_pc4),
    .i_pipe_rf_en        (pipe_rf_en),
    .i_pipe_wb_sel       (pipe_wb_sel),
    .o_wb_stall          (wb_stall),
    .i_ll_valid          (ll_valid),
    .o_ll_ready          (ll_ready),
    .i_ll_rd             (ll_rd),
    .i_ll_data           (ll_data),
    .o_rf_we             (rf_we),
    .o_rf_waddr          (rf_waddr),
    .o_rf_wdata          (rf_wdata),
    .o_ll_pending        (ll_pending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe_wr(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] opr);
    pipe_valid   = 1'b1;
    pipe_rf_en   = 1'b1;
    pipe_rd      = rd;
    pipe_wb_sel  = sel;
    pipe_opr_res = opr;
  endtask

  task automatic pipe_idle();
    pipe_valid = 1'b0;
    pipe_rf_en = 1'b0;
  endtask

  function automatic logic [31:0] ld_exp(input logic [31:0] sub);
`ifdef WB_LOAD_SUBWORD_EN
    return sub;
`else
    return c_raw;
`endif
  endfunction

  task automatic do_load(input string tag, input logic [1:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] sub);
    pipe_wr(5'd6, 2'b01, 32'h0);
    pipe_dmem_rdata   = c_raw;
    pipe_addr_lo      = addr;
    pipe_mem_size     = size;
    pipe_mem_unsigned = uns;
    tick();
    chk(tag, rf_wdata, ld_exp(sub));
  endtask

  // Fill-test expectation tables, indexed by cycle
  int          ent_tab   [10];
  logic [31:0] exp_ready [10];
  logic [31:0] exp_pend  [10];
  logic [31:0] exp_we    [10];
  logic [31:0] exp_addr  [10];
  logic [31:0] exp_data  [10];

  initial begin
    rst = 1'b1;
    pipe_valid = 1'b0; pipe_opr_res = '0; pipe_dmem_rdata = '0; pipe_addr_lo = '0;
    pipe_mem_size = '0; pipe_mem_unsigned = 1'b0; pipe_rd = '0; pipe_pc4 = 32'h0000_1004;
    pipe_rf_en = 1'b0; pipe_wb_sel = '0; ll_valid = 1'b0; ll_rd = '0; ll_data = '0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_pend", ll_pending, 0);
    chk("rst_ready", ll_ready, 0);
    chk("rst_stall", wb_stall, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", ll_ready, 1);
    tick();

    // ---------------- basic pipe write ----------------
    pipe_wr(5'd5, 2'b00, 32'h1234_5678);
    tick();
    chk("pw_we", rf_we, 1);
    chk("pw_waddr", rf_waddr, 5);
    chk("pw_wdata", rf_wdata, 32'h1234_5678);
    pipe_idle();
    tick();
    chk("idle_we", rf_we, 0);

    // ---------------- load extraction ----------------
    do_load("lb_s_a3", 2'd3, 2'b00, 1'b0, 32'hFFFF_FF80);
    do_load("lbu_a3", 2'd3, 2'b00, 1'b1, 32'h0000_0080);
    do_load("lh_s_a2", 2'd2, 2'b01, 1'b0, 32'hFFFF_80FF);
    do_load("lhu_a1", 2'd1, 2'b01, 1'b1, 32'h0000_7F01);
    do_load("lb_s_a0", 2'd0, 2'b00, 1'b0, 32'h0000_0001);
    do_load("lb_s_a1", 2'd1, 2'b00, 1'b0, 32'h0000_007F);
    do_load("lw_a3", 2'd3, 2'b10, 1'b0, c_raw);

    pipe_wr(5'd8, 2'b10, 32'h0);
    tick();
    chk("pc4_wdata", rf_wdata, 32'h0000_1004);
    pipe_wr(5'd8, 2'b11, 32'hFFFF_FFFF);
    tick();
    chk("sel11_wdata", rf_wdata, 0);
    chk("sel11_we", rf_we, 1);
    pipe_wr(5'd0, 2'b00, 32'hDEAD_BEEF);
    tick();
    chk("rd0_we", rf_we, 0);
    pipe_idle();
    tick();

    // ---------------- single LL result, pipe idle ----------------
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'hA5A5_A5A5;
    #1;
    chk("ll_ready", ll_ready, 1);
    tick();
    ll_valid = 1'b0;
    chk("ll_pend1", ll_pending, 1);
    chk("ll_we_early", rf_we, 0);
    tick();
    chk("ll_we", rf_we, 1);
    chk("ll_waddr", rf_waddr, 7);
    chk("ll_wdata", rf_wdata, 32'hA5A5_A5A5);
    chk("ll_pend0", ll_pending, 0);

    // ---------------- starvation ----------------
    for (int k = 0; k < 6; k++) begin
      pipe_wr(5'd9, 2'b00, c_b1 + 32'(k));
      if (k == 0) begin
        ll_valid = 1'b1; ll_rd = 5'd3; ll_data = 32'hCAFE_0003;
      end
      #1;
      chk($sformatf("sv_stall_c%0d", k), wb_stall, (k == 5) ? 1 : 0);
      tick();
      ll_valid = 1'b0;
      if (k < 5) begin
        chk($sformatf("sv_waddr_c%0d", k), rf_waddr, 9);
        chk($sformatf("sv_wdata_c%0d", k), rf_wdata, c_b1 + 32'(k));
      end else begin
        chk("sv_ll_waddr", rf_waddr, 3);
        chk("sv_ll_wdata", rf_wdata, 32'hCAFE_0003);
      end
    end
    #1;
    chk("sv_stall_c6", wb_stall, 0);
    tick();
    chk("sv_held_waddr", rf_waddr, 9);
    chk("sv_held_wdata", rf_wdata, c_b1 + 32'd5);
    chk("sv_pend", ll_pending, 0);

    // ---------------- fill FIFO under continuous pipe writes ----------------
    ent_tab   = '{0, 1, 2, 2, 2, 2, 2, -1, -1, -1};
    exp_ready = '{1, 1, 0, 0, 0, 0, 1, 0, 1, 1};
    exp_pend  = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    exp_we    = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    exp_addr  = '{10, 10, 10, 10, 10, 16, 10, 17, 18, 0};
    exp_data  = '{c_b2, c_b2 + 1, c_b2 + 2, c_b2 + 3, c_b2 + 4,
                  c_d, c_b2 + 5, c_d + 1, c_d + 2, 0};
    for (int c = 0; c < 10; c++) begin
      if (c <= 4)      pipe_wr(5'd10, 2'b00, c_b2 + 32'(c));
      else if (c <= 6) pipe_wr(5'd10, 2'b00, c_b2 + 32'd5);
      else             pipe_idle();
      if (ent_tab[c] >= 0) begin
        ll_valid = 1'b1;
        ll_rd    = 5'(16 + ent_tab[c]);
        ll_data  = c_d + 32'(ent_tab[c]);
      end else begin
        ll_valid = 1'b0;
      end
      #1;
      chk($sformatf("fl_ready_c%0d", c), ll_ready, exp_ready[c]);
      chk($sformatf("fl_pend_c%0d", c), ll_pending, exp_pend[c]);
      chk($sformatf("fl_stall_c%0d", c), wb_stall, (c == 5) ? 1 : 0);
      tick();
      chk($sformatf("fl_we_c%0d", c), rf_we, exp_we[c]);
      if (c < 9) begin
        chk($sformatf("fl_waddr_c%0d", c), rf_waddr, exp_addr[c]);
        chk($sformatf("fl_wdata_c%0d", c), rf_wdata, exp_data[c]);
      end
    end

    // ---------------- reset with two entries queued ----------------
    pipe_wr(5'd11, 2'b00, 32'h3333_0000);
    ll_valid = 1'b1; ll_rd = 5'd21; ll_data = 32'hE000_0000;
    tick();
    ll_rd = 5'd22; ll_data = 32'hE000_0001;
    tick();
    ll_valid = 1'b0;
    chk("mr_we_before", rf_we, 1);
    chk("mr_pend_before", ll_pending, 1);
    chk("mr_ready_full", ll_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_we_async", rf_we, 0);
    chk("mr_pend_rst", ll_pending, 0);
    chk("mr_ready_rst", ll_ready, 0);
    chk("mr_stall_rst", wb_stall, 0);
    pipe_idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("mr_pend_rel", ll_pending, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("mr_no_stale_%0d", i), rf_we, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
